x_div_seq_32: RTL and testbench

- Multicycle signed 32-bit divider for the processor's multdiv path.
- It is the inverse of the carry-select adder datapath: the adder composes a sum, this block decomposes a dividend by repeated trial subtraction.
- Radix-2 restoring algorithm, one quotient bit per cycle.
- Sits beside the ALU. The pipeline stalls on busy and consumes quotient/remainder on result_valid.

---
 rtl/x_multdiv_pkg.sv | 14 +
 rtl/x_div_step_32.sv | 25 ++
 rtl/x_div_seq_32.sv | 117 +++++++++++
 tb/tb_x_div_seq_32.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/x_multdiv_pkg.sv
// Shared definitions for the multdiv path: divider FSM encoding and constants.
package x_multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/x_div_step_32.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial-subtract, restore on borrow.
module x_div_step_32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dq_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           borrow;

  // rem < |divisor| <= 2^(WIDTH-1), so the shifted value fits and bit WIDTH of trial is a true sign
  always_comb begin
    rem_sh   = {rem, dq_msb};
    trial    = rem_sh - {1'b0, dvs};
    borrow   = trial[WIDTH];
    q_bit    = ~borrow;
    rem_next = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/x_div_seq_32.sv
// Multicycle signed divider: magnitudes are divided by restoring iteration, signs fixed up in one final cycle.
module x_div_seq_32
  import x_multdiv_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS,
  parameter int CNT_W = 6
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic                    busy,
  output logic                    result_valid,
  output logic signed [WIDTH-1:0] quotient,
  output logic signed [WIDTH-1:0] remainder,
  output logic                    div_by_zero,
  output logic                    overflow
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, dq, dvs;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic             sign_q, sign_r, ovf_pend;

  // Two's-complement negate as invert plus carry-in
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // INT_MIN maps to itself, which is the correct unsigned magnitude
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? negate(x) : x;
  endfunction

  x_div_step_32 #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dq_msb   (dq[WIDTH-1]),
    .dvs      (dvs),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC: if (cnt == LAST_CNT) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt         <= '0;
      rem         <= '0;
      dq          <= '0;
      dvs         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      ovf_pend    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt         <= '0;
          rem         <= '0;
          dq          <= magnitude(dividend);
          dvs         <= magnitude(divisor);
          sign_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sign_r      <= dividend[WIDTH-1];
          ovf_pend    <= (dividend == INT_MIN) && (divisor == '1);
          div_by_zero <= (divisor == '0);
          overflow    <= 1'b0;
          if (divisor == '0) begin
            quotient  <= '0;
            remainder <= dividend;
          end
        end
        CALC: begin
          rem <= step_rem;
          dq  <= {dq[WIDTH-2:0], step_q};
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          overflow <= ovf_pend;
          if (ovf_pend) begin
            quotient  <= INT_MIN;
            remainder <= '0;
          end else begin
            quotient  <= sign_q ? negate(dq) : dq;
            remainder <= sign_r ? negate(rem) : rem;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state != IDLE);
  assign result_valid = (state == DONE);

endmodule

// File: tb/tb_x_div_seq_32.sv
// Randomized and directed bench for x_div_seq_32 against an arithmetic reference model.
module tb_x_div_seq_32;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, result_valid, div_by_zero, overflow;
  logic [31:0] quotient, remainder;

  int n_chk = 0;
  int n_err = 0;

  x_div_seq_32 dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .dividend     (dividend),
    .divisor      (divisor),
    .busy         (busy),
    .result_valid (result_valid),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_by_zero  (div_by_zero),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eq, output logic [31:0] er,
                                output logic ez, output logic eo);
    int sa, sb;
    sa = a;
    sb = b;
    ez = 1'b0;
    eo = 1'b0;
    if (sb == 0) begin
      ez = 1'b1; eq = 32'd0; er = a;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      eo = 1'b1; eq = 32'h8000_0000; er = 32'd0;
    end else begin
      eq = sa / sb;
      er = sa % sb;
    end
  endfunction

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int repulse_at);
    logic [31:0] eq, er;
    logic        ez, eo, busy_ok;
    int          k, exp_lat;
    model(a, b, eq, er, ez, eo);
    exp_lat = (b == 0) ? 1 : 34;
    @(negedge clock);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clock);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    k = 1;
    busy_ok = 1'b1;
    while (!result_valid && k < 100) begin
      if (!busy) busy_ok = 1'b0;
      if (k == repulse_at) begin
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      k++;
    end
    start = 1'b0;
    chk("latency", 32'(k), 32'(exp_lat));
    chk("busy_during", 32'(busy_ok & busy), 32'd1);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", 32'(div_by_zero), 32'(ez));
    chk("overflow", 32'(overflow), 32'(eo));
    @(negedge clock);
    chk("valid_pulse", 32'(result_valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("quotient_hold", quotient, eq);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        quiet;
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    reset_n = 1'b1;

    do_div(32'd100, 32'd7, 0);
    do_div(-32'sd100, 32'd7, 0);
    do_div(32'd100, -32'sd7, 0);
    do_div(-32'sd100, -32'sd7, 0);
    do_div(32'd5, 32'd0, 0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_div(32'h8000_0000, 32'd1, 0);
    do_div(32'h8000_0000, 32'h8000_0000, 0);
    do_div(32'h7FFF_FFFF, 32'h8000_0000, 0);
    do_div(32'd40, 32'd6, 10);
    do_div(32'd9, 32'd3, 0);

    // abort mid-operation with reset
    @(negedge clock);
    start = 1'b1; dividend = 32'd1000; divisor = 32'd10;
    @(negedge clock);
    start = 1'b0;
    repeat (14) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(result_valid), 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    reset_n = 1'b1;
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clock);
      if (result_valid || busy) quiet = 1'b0;
    end
    chk("abort_quiet", 32'(quiet), 32'd1);
    do_div(32'd7, 32'd2, 0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1);
        2: rb = (i % 8 == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
        default: begin ra = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : ra; rb = $urandom >> 20; end
      endcase
      do_div(ra, rb, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
